// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus agent: transaction encoding, default wait counts
// and the strobe classifier.
package z80_bus_pkg;

    typedef enum logic [2:0] {
        TxnFetch   = 3'd0,
        TxnMemRd   = 3'd1,
        TxnMemWr   = 3'd2,
        TxnIoRd    = 3'd3,
        TxnIoWr    = 3'd4,
        TxnInta    = 3'd5,
        TxnRefresh = 3'd6
    } txn_t;

    localparam int unsigned DefWaitFetch = 0;
    localparam int unsigned DefWaitMem   = 0;
    localparam int unsigned DefWaitIo    = 1;

    typedef struct packed {
        logic active;
        txn_t ttype;
    } class_s;

    // Priority order matters: refresh and INTA overlap the memory/IO rules.
    function automatic class_s classify(input logic n_m1, input logic n_mreq,
                                        input logic n_iorq, input logic n_rd,
                                        input logic n_wr, input logic n_rfsh);
        class_s c;
        c.active = 1'b1;
        c.ttype  = TxnFetch;
        if (!n_mreq && !n_rfsh)              c.ttype = TxnRefresh;
        else if (!n_m1 && !n_iorq)           c.ttype = TxnInta;
        else if (!n_m1 && !n_mreq && !n_rd)  c.ttype = TxnFetch;
        else if (!n_mreq && !n_rd)           c.ttype = TxnMemRd;
        else if (!n_mreq && !n_wr)           c.ttype = TxnMemWr;
        else if (!n_iorq && !n_rd)           c.ttype = TxnIoRd;
        else if (!n_iorq && !n_wr)           c.ttype = TxnIoWr;
        else                                 c.active = 1'b0;
        return c;
    endfunction

endpackage

`define Z80_TXN_S(AW, DW) struct packed { z80_bus_pkg::txn_t ttype; logic [(AW)-1:0] addr; logic [(DW)-1:0] data; }

// File: rtl/z80_txn_fifo.sv
// Capture FIFO for bus transactions: registered storage, level counter and
// sticky overflow with a saturating drop counter.
module z80_txn_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    assign valid   = (level != '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/z80_bus_agent.sv
// Bench-side Z80 bus agent: classifies bus cycles, inserts wait states on nWAIT
// and records completed transactions into a capture FIFO.
module z80_bus_agent
    import z80_bus_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned WAIT_FETCH   = DefWaitFetch,
    parameter int unsigned WAIT_MEM     = DefWaitMem,
    parameter int unsigned WAIT_IO      = DefWaitIo,
    parameter logic [6:0]  CAPTURE_MASK = 7'h3F
) (
    input  logic                    CPUCLK,
    input  logic                    RESET,
    input  logic                    nM1,
    input  logic                    nMREQ,
    input  logic                    nIORQ,
    input  logic                    nRD,
    input  logic                    nWR,
    input  logic                    nRFSH,
    input  logic [ADDR_W-1:0]       A,
    input  logic [DATA_W-1:0]       D,
    input  logic                    wait_en,
    output logic                    nWAIT,
    output logic                    txn_valid,
    input  logic                    txn_ready,
    output txn_t                    txn_type,
    output logic [ADDR_W-1:0]       txn_addr,
    output logic [DATA_W-1:0]       txn_data,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    output logic [7:0]              drop_count
);

    typedef `Z80_TXN_S(ADDR_W, DATA_W) txn_s;

    typedef enum logic [2:0] {
        StSync,
        StIdle,
        StWait,
        StCapt,
        StHold
    } state_e;

    localparam logic [7:0] MaskExt = {1'b0, CAPTURE_MASK};

    state_e            state;
    txn_t              cur_type;
    logic [ADDR_W-1:0] cur_addr;
    logic [3:0]        cnt;
    logic [3:0]        wait_load;
    class_s            cls;
    logic              bus_idle;
    logic              push;
    txn_s              push_txn;
    txn_s              head_txn;

    assign cls      = classify(nM1, nMREQ, nIORQ, nRD, nWR, nRFSH);
    assign bus_idle = nMREQ && nIORQ;

    always_comb begin
        wait_load = 4'd0;
        if (wait_en) begin
            case (cls.ttype)
                TxnFetch:                  wait_load = 4'(WAIT_FETCH);
                TxnMemRd, TxnMemWr:        wait_load = 4'(WAIT_MEM);
                TxnIoRd, TxnIoWr, TxnInta: wait_load = 4'(WAIT_IO);
                default:                   wait_load = 4'd0;
            endcase
        end
    end

    always_ff @(posedge CPUCLK) begin
        if (RESET) begin
            state    <= StSync;
            nWAIT    <= 1'b1;
            cnt      <= 4'd0;
            cur_type <= TxnFetch;
            cur_addr <= '0;
        end else begin
            case (state)
                // A cycle already in flight at reset release is skipped.
                StSync: if (bus_idle) state <= StIdle;
                StIdle: begin
                    if (cls.active) begin
                        cur_type <= cls.ttype;
                        cur_addr <= A;
                        cnt      <= wait_load;
                        if (wait_load != 4'd0) begin
                            nWAIT <= 1'b0;
                            state <= StWait;
                        end else begin
                            state <= StCapt;
                        end
                    end
                end
                StWait: begin
                    if (bus_idle) begin
                        nWAIT <= 1'b1;
                        state <= StIdle;
                    end else if (cnt == 4'd1) begin
                        nWAIT <= 1'b1;
                        state <= StCapt;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StCapt: state <= StHold;
                // One transaction per strobe assertion, however long it is held.
                StHold: if (bus_idle) state <= StIdle;
                default: state <= StSync;
            endcase
        end
    end

    assign push           = (state == StCapt) && MaskExt[cur_type];
    assign push_txn.ttype = cur_type;
    assign push_txn.addr  = cur_addr;
    assign push_txn.data  = (cur_type == TxnInta || cur_type == TxnRefresh) ? '0 : D;

    z80_txn_fifo #(
        .WIDTH ($bits(txn_s)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (CPUCLK),
        .rst        (RESET),
        .push       (push),
        .push_data  (push_txn),
        .pop        (txn_ready),
        .valid      (txn_valid),
        .head       (head_txn),
        .level      (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    assign txn_type = head_txn.ttype;
    assign txn_addr = head_txn.addr;
    assign txn_data = head_txn.data;

endmodule

// File: tb/tb_z80_bus_agent.sv
// Directed bench for z80_bus_agent: two instances differing only in CAPTURE_MASK.
module tb_z80_bus_agent;
    import z80_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        n_m1 = 1'b1, n_mreq = 1'b1, n_iorq = 1'b1;
    logic        n_rd = 1'b1, n_wr = 1'b1, n_rfsh = 1'b1;
    logic [15:0] addr = 16'h0;
    logic [7:0]  data = 8'h0;
    logic        wait_en = 1'b1;
    logic        ready = 1'b0;

    logic        nwait_a, valid_a, ovf_a, nwait_b, valid_b, ovf_b;
    txn_t        type_a, type_b;
    logic [15:0] taddr_a, taddr_b;
    logic [7:0]  tdata_a, tdata_b, drop_a, drop_b;
    logic [2:0]  level_a, level_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    z80_bus_agent #(
        .ADDR_W(16), .DATA_W(8), .DEPTH(4), .WAIT_FETCH(2), .WAIT_MEM(0), .WAIT_IO(1),
        .CAPTURE_MASK(7'h3F)
    ) dut_a (
        .CPUCLK(clk), .RESET(rst), .nM1(n_m1), .nMREQ(n_mreq), .nIORQ(n_iorq),
        .nRD(n_rd), .nWR(n_wr), .nRFSH(n_rfsh), .A(addr), .D(data), .wait_en(wait_en),
        .nWAIT(nwait_a), .txn_valid(valid_a), .txn_ready(ready), .txn_type(type_a),
        .txn_addr(taddr_a), .txn_data(tdata_a), .fifo_level(level_a), .overflow(ovf_a),
        .drop_count(drop_a)
    );

    z80_bus_agent #(
        .ADDR_W(16), .DATA_W(8), .DEPTH(4), .WAIT_FETCH(2), .WAIT_MEM(0), .WAIT_IO(1),
        .CAPTURE_MASK(7'h7F)
    ) dut_b (
        .CPUCLK(clk), .RESET(rst), .nM1(n_m1), .nMREQ(n_mreq), .nIORQ(n_iorq),
        .nRD(n_rd), .nWR(n_wr), .nRFSH(n_rfsh), .A(addr), .D(data), .wait_en(wait_en),
        .nWAIT(nwait_b), .txn_valid(valid_b), .txn_ready(ready), .txn_type(type_b),
        .txn_addr(taddr_b), .txn_data(tdata_b), .fifo_level(level_b), .overflow(ovf_b),
        .drop_count(drop_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        n_m1 = 1'b1; n_mreq = 1'b1; n_iorq = 1'b1;
        n_rd = 1'b1; n_wr = 1'b1; n_rfsh = 1'b1;
    endtask

    task automatic apply_reset();
        release_bus();
        ready = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic pop_one();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    task automatic test_reset();
        int lows;
        rst = 1'b1;
        n_mreq = 1'b0; n_rd = 1'b0; addr = 16'h0077; data = 8'h11;
        tick(2);
        @(negedge clk);
        n_tests++;
        if (nwait_a !== 1'b1 || valid_a !== 1'b0 || level_a !== 3'd0 || ovf_a !== 1'b0 ||
            drop_a !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values: nwait=%b valid=%b level=%0d ovf=%b drop=%0d, want 1 0 0 0 0",
                     nwait_a, valid_a, level_a, ovf_a, drop_a);
        end
        tick(1);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (nwait_a === 1'b0) lows++;
        end
        n_tests++;
        if (lows != 0 || level_a !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_inflight: nwait_low=%0d level=%0d, want 0 0", lows, level_a);
        end
        tick(1);
        release_bus();
        tick(1);
        n_mreq = 1'b0; n_rd = 1'b0; addr = 16'h1234; data = 8'hA5;
        tick(3);
        release_bus();
        @(negedge clk);
        n_tests++;
        if (level_a !== 3'd1 || type_a !== TxnMemRd || taddr_a !== 16'h1234 ||
            tdata_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_first_txn: level=%0d type=%0d addr=%h data=%h, want 1 1 1234 a5",
                     level_a, type_a, taddr_a, tdata_a);
        end
        tick(1);
    endtask

    task automatic test_fetch();
        logic [5:0] w;
        apply_reset();
        wait_en = 1'b1;
        n_m1 = 1'b0; n_mreq = 1'b0; n_rd = 1'b0; addr = 16'h0000; data = 8'h3E;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            w[i] = nwait_a;
        end
        n_tests++;
        if (w !== 6'b111001) begin
            n_fail++;
            $display("FAIL fetch_nwait: got %b want 111001", w);
        end
        n_tests++;
        if (valid_a !== 1'b1 || level_a !== 3'd1 || type_a !== TxnFetch ||
            taddr_a !== 16'h0000 || tdata_a !== 8'h3E) begin
            n_fail++;
            $display("FAIL fetch_capture: valid=%b level=%0d type=%0d addr=%h data=%h, want 1 1 0 0000 3e",
                     valid_a, level_a, type_a, taddr_a, tdata_a);
        end
        tick(1);
        release_bus();
        tick(1);
        pop_one();
        @(negedge clk);
        n_tests++;
        if (level_a !== 3'd0 || valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_pop: level=%0d valid=%b, want 0 0", level_a, valid_a);
        end
        tick(1);
    endtask

    task automatic test_io();
        int lows;
        apply_reset();
        for (int pass = 0; pass < 2; pass++) begin
            wait_en = (pass == 0);
            n_iorq = 1'b0; n_wr = 1'b0; addr = 16'h00FE; data = 8'h55;
            lows = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (nwait_a === 1'b0) lows++;
            end
            n_tests++;
            if (lows != ((pass == 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL io_wait_pass%0d: nwait_low=%0d want %0d", pass, lows,
                         (pass == 0) ? 1 : 0);
            end
            tick(1);
            release_bus();
            tick(2);
        end
        wait_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (level_a !== 3'd2) begin
            n_fail++;
            $display("FAIL io_level: got %0d want 2", level_a);
        end
        tick(1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (type_a !== TxnIoWr || taddr_a !== 16'h00FE || tdata_a !== 8'h55) begin
                n_fail++;
                $display("FAIL io_entry%0d: type=%0d addr=%h data=%h, want 4 00fe 55",
                         k, type_a, taddr_a, tdata_a);
            end
            tick(1);
            pop_one();
        end
        pop_one();
        @(negedge clk);
        n_tests++;
        if (level_a !== 3'd0 || valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_empty: level=%0d valid=%b, want 0 0", level_a, valid_a);
        end
        tick(1);
    endtask

    task automatic test_refresh();
        int lows;
        apply_reset();
        wait_en = 1'b1;
        n_mreq = 1'b0; n_rfsh = 1'b0; addr = 16'h0042; data = 8'hAA;
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (nwait_a === 1'b0 || nwait_b === 1'b0) lows++;
        end
        n_tests++;
        if (lows != 0 || level_a !== 3'd0) begin
            n_fail++;
            $display("FAIL refresh_default: nwait_low=%0d level=%0d, want 0 0", lows, level_a);
        end
        n_tests++;
        if (level_b !== 3'd1 || type_b !== TxnRefresh || taddr_b !== 16'h0042 ||
            tdata_b !== 8'h00) begin
            n_fail++;
            $display("FAIL refresh_masked: level=%0d type=%0d addr=%h data=%h, want 1 6 0042 00",
                     level_b, type_b, taddr_b, tdata_b);
        end
        tick(1);
        release_bus();
        tick(2);
    endtask

    task automatic test_overflow();
        apply_reset();
        wait_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_mreq = 1'b0; n_wr = 1'b0; addr = 16'(i); data = 8'h10 + 8'(i);
            tick(3);
            release_bus();
            tick(1);
        end
        @(negedge clk);
        n_tests++;
        if (level_a !== 3'd4 || ovf_a !== 1'b1 || drop_a !== 8'd2) begin
            n_fail++;
            $display("FAIL overflow_counts: level=%0d ovf=%b drop=%0d, want 4 1 2",
                     level_a, ovf_a, drop_a);
        end
        n_tests++;
        if (type_a !== TxnMemWr || taddr_a !== 16'h0000 || tdata_a !== 8'h10) begin
            n_fail++;
            $display("FAIL overflow_head: type=%0d addr=%h data=%h, want 2 0000 10",
                     type_a, taddr_a, tdata_a);
        end
        tick(1);
        n_mreq = 1'b0; n_wr = 1'b0; addr = 16'h0020; data = 8'h30;
        tick(1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (level_a !== 3'd4 || drop_a !== 8'd2 || taddr_a !== 16'h0001) begin
            n_fail++;
            $display("FAIL full_push_pop: level=%0d drop=%0d head=%h, want 4 2 0001",
                     level_a, drop_a, taddr_a);
        end
        tick(1);
        release_bus();
        tick(2);
    endtask

    task automatic test_reset_mid();
        wait_en = 1'b1;
        n_m1 = 1'b0; n_mreq = 1'b0; n_rd = 1'b0; addr = 16'h0100; data = 8'h00;
        tick(1);
        @(negedge clk);
        n_tests++;
        if (nwait_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait_entry: nwait=%b want 0", nwait_a);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (nwait_a !== 1'b1 || level_a !== 3'd0 || ovf_a !== 1'b0 || drop_a !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: nwait=%b level=%0d ovf=%b drop=%0d, want 1 0 0 0",
                     nwait_a, level_a, ovf_a, drop_a);
        end
        tick(1);
        rst = 1'b0;
        release_bus();
        tick(2);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_io();
        test_refresh();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_bus_agent.md
Name: z80_bus_agent

Overview:
- Parametrised, cycle-accurate bus agent that sits on the bench side of the Z80 pin interface.
- Watches the CPU control strobes and classifies every bus cycle.
- Inserts a per-cycle-type, parameter-set number of wait states by driving nWAIT.
- Captures completed transactions into an internal FIFO that the bench scoreboard drains through a valid/ready port. This generalises the fixed 16/8-bit pin bundle to configurable widths, depth and modes.

Parameters:
ADDR_W, 16, address bus width
DATA_W, 8, data bus width
DEPTH, 8, capture FIFO entries; power of 2, 2..256
WAIT_FETCH, 0, wait states on M1 opcode fetch (0..15)
WAIT_MEM, 0, wait states on memory read/write (0..15)
WAIT_IO, 1, wait states on I/O read/write and interrupt acknowledge (0..15)
CAPTURE_MASK, 7'h3F, bit per txn type; 1 = push to FIFO (refresh off by default)

Ports:
CPUCLK  in  1  clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
nM1, nMREQ, nIORQ, nRD, nWR, nRFSH  in  1 each  CPU strobes, active low, sampled each edge
A  in  ADDR_W  address bus
D  in  DATA_W  data bus, sampled only (agent never drives D)
wait_en  in  1  1 = insert parameter wait states; 0 = zero waits
nWAIT  out  1  wait request to CPU, active low, registered
txn_valid  out  1  FIFO head valid
txn_ready  in  1  consumer accepts head
txn_type  out  3  z80_bus_pkg::txn_t of head
txn_addr  out  ADDR_W  captured address
txn_data  out  DATA_W  captured data (0 for REFRESH/INTA)
fifo_level  out  $clog2(DEPTH)+1  occupied entries
overflow  out  1  sticky; a push was dropped while the FIFO was full
drop_count  out  8  dropped pushes; saturates at 255

Behaviour:
- Reset values: nWAIT=1, txn_valid=0, fifo_level=0, overflow=0, drop_count=0, state=SYNC.
- Classification is combinational on the sampled strobes; the first matching rule wins:
  - REFRESH: nMREQ=0 & nRFSH=0.
  - INTA: nM1=0 & nIORQ=0.
  - FETCH: nM1=0 & nMREQ=0 & nRD=0.
  - MEM_RD / MEM_WR: nMREQ=0 & nRD=0 / nWR=0.
  - IO_RD / IO_WR: nIORQ=0 & nRD=0 / nWR=0.
  - Otherwise: none (active = 0).
  - Encoding: FETCH=0, MEM_RD=1, MEM_WR=2, IO_RD=3, IO_WR=4, INTA=5, REFRESH=6.
- FSM:
  - SYNC: wait until nMREQ=nIORQ=1 for one edge, then IDLE. A cycle already in flight at reset release is ignored.
  - IDLE, active=1:
    - Latch type and A.
    - Load cnt = wait_en ? WAIT_x : 0. REFRESH always uses 0.
    - cnt>0 -> WAIT and nWAIT<=0 on the same edge, so nWAIT is low starting the cycle after detection.
    - cnt=0 -> CAPT.
  - WAIT: cnt decrements each edge. When cnt reaches 1, nWAIT<=1 and go to CAPT. Total nWAIT-low cycles = WAIT_x.
  - CAPT (one cycle):
    - Sample D; INTA/REFRESH store 0.
    - Push {type, addr, data} if CAPTURE_MASK[type].
    - Go to HOLD.
  - HOLD: wait until nMREQ=nIORQ=1, then IDLE. This gives one transaction per strobe assertion, however long it lasts.
  - Strobes deasserting early (in WAIT): abort to IDLE, nWAIT<=1, no push.
- FIFO:
  - Push when full and no pop: drop, overflow<=1, drop_count++ (saturating).
  - Push and pop in the same cycle while full: both succeed, level unchanged, no drop.
  - Pop when empty: ignored.
  - txn_* outputs are stable while txn_valid=1 & txn_ready=0.
  - Pointers wrap modulo DEPTH. Push-to-visible latency is 1 cycle; head data is registered.
- RESET mid-transaction: nWAIT returns to 1 on the next edge, the FIFO is flushed, and the FSM enters SYNC.

Decomposition:
- Package z80_bus_pkg:
  - typedef enum logic[2:0] txn_t.
  - Parametrised struct z80_txn_s {type, addr, data}, using a parameterised class wrapper or a macro for widths.
  - localparams for default wait counts.
  - Function classify(strobes) -> {active, txn_t}.
- Sub-module z80_txn_fifo:
  - Parameters WIDTH, DEPTH.
  - Owns the push/pop pointers, the level counter and the overflow/drop counter.
- The agent top holds the FSM and wait counter.

Test Plan:
- RESET asserted, then released with nMREQ=0 and nRD=0 held for 3 cycles -> no push, nWAIT stays 1, state SYNC->IDLE only after strobes go high.
- M1 fetch of A=16'h0000, D=8'h3E, WAIT_FETCH=2, wait_en=1 -> nWAIT low exactly 2 cycles starting the cycle after detection; FIFO gets {FETCH, 16'h0000, 8'h3E}.
- I/O write A=16'h00FE, D=8'h55, WAIT_IO=1, then wait_en=0 repeat -> first 1 nWAIT cycle, second 0; both IO_WR entries captured with data 8'h55.
- Refresh cycle during fetch T3/T4 with default CAPTURE_MASK -> no push, nWAIT never low; with mask bit 6 set -> {REFRESH, A, 0} pushed.
- DEPTH=4, 6 memory writes with txn_ready=0 -> fifo_level=4, overflow=1, drop_count=2; then pop and push in the same cycle while full -> level stays 4, drop_count stays 2.
- RESET pulsed while nWAIT=0 in WAIT -> next edge nWAIT=1, fifo_level=0, overflow=0.
